// File: rtl/imem_if.sv
// imem_if: instruction memory req/ack bus between fetch unit and memory
interface imem_if #(
  parameter int PC_WIDTH = 8
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;
  logic [15:0]         imem_rdata;
  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, instruction fetch over req/ack, IR latch and field decode
module instr_fetch_unit #(
  parameter int PC_WIDTH   = 8,
  parameter int DATA_WIDTH = 8,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_en,
  input  logic                  next_pc,
  input  logic                  pc_src,
  imem_if.master                imem,
  output logic                  instr_valid,
  output logic [3:0]            opcode,
  output logic [2:0]            rd,
  output logic [2:0]            rs1,
  output logic [2:0]            rs2,
  output logic [DATA_WIDTH-1:0] imm,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  halted
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;
  state_t              state, state_n;
  logic [15:0]         ir, ir_n;
  logic [PC_WIDTH-1:0] pc_n, target;
  logic                req;
  assign opcode         = ir[15:12];
  assign rd             = ir[11:9];
  assign rs1            = ir[8:6];
  assign rs2            = ir[5:3];
  assign imm            = {{(DATA_WIDTH-6){ir[5]}}, ir[5:0]};
  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;
  assign target = !pc_src ? pc + PC_WIDTH'(1) :
                  opcode == 4'b0111 ? ir[PC_WIDTH-1:0] :
                  pc + PC_WIDTH'(1) + {{(PC_WIDTH-6){ir[5]}}, ir[5:0]};
  // next-state: IR captured on ack, PC advanced only when a held instruction retires
  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    unique case (state)
      IDLE:  state_n = fetch_en ? FETCH : IDLE;
      FETCH: if (imem.imem_ack) begin
        ir_n    = imem.imem_rdata;
        state_n = imem.imem_rdata[15:12] == 4'b1111 ? HALT : HOLD;
      end
      HOLD:  if (next_pc) begin
        pc_n    = target;
        state_n = FETCH;
      end
      HALT:  state_n = HALT;
    endcase
  end
  // state register; status outputs registered from the next state so they switch cleanly
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= PC_WIDTH'(RESET_PC);
      ir          <= '0;
      req         <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      ir          <= ir_n;
      req         <= state_n == FETCH;
      instr_valid <= state_n == HOLD || state_n == HALT;
      halted      <= state_n == HALT;
    end
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Upstream neighbour of control_unit. Holds the PC, fetches 16-bit instructions from instruction memory over a req/ack handshake, and latches them into an instruction register. Decodes the opcode and operand fields for control_unit and the datapath. Computes the next PC: sequential, branch (PC-relative) or jump (absolute), selected by control_unit's PCSrc.

Parameters:
PC_WIDTH, 8, PC and imem address width; legal range 6..12.
DATA_WIDTH, 8, width of the sign-extended immediate output.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
fetch_en  in  1  leave IDLE and start fetching at current PC
next_pc  in  1  strobe from control_unit: instruction retired, advance PC and fetch
pc_src  in  1  control_unit PCSrc, sampled with next_pc: 0 = PC+1, 1 = target
imem_req  out  1  instruction memory request, registered
imem_addr  out  PC_WIDTH  fetch address, always equals pc
imem_ack  in  1  memory has imem_rdata valid this cycle
imem_rdata  in  16  instruction word
instr_valid  out  1  IR holds a fetched instruction; decoded outputs are valid
opcode  out  4  IR[15:12]
rd  out  3  IR[11:9]
rs1  out  3  IR[8:6]
rs2  out  3  IR[5:3]
imm  out  DATA_WIDTH  sign-extended IR[5:0]
pc  out  PC_WIDTH  current PC
halted  out  1  HALT opcode (4'b1111) fetched

Behaviour:
- Reset, synchronous: state=IDLE, pc=RESET_PC, IR=0, imem_req=0, instr_valid=0, halted=0. Reset overrides every other input, including a pending ack mid-fetch. That ack is discarded.
- States: IDLE, FETCH, HOLD, HALT.
- IDLE:
  - fetch_en=1 → FETCH, imem_req=1 from the next cycle.
  - next_pc and imem_ack are ignored.
- FETCH:
  - imem_req=1 and imem_addr=pc are held stable until ack.
  - On an edge with imem_ack=1: IR<=imem_rdata, imem_req<=0, instr_valid<=1.
  - Then → HALT if imem_rdata[15:12]==4'b1111, else → HOLD.
  - next_pc is ignored in FETCH.
- Fetch latency: req visible the cycle after entry. A zero-wait memory (ack in the same cycle as req) gives instr_valid 1 cycle after req rises. Wait states extend FETCH without limit.
- HOLD:
  - IR and the decoded outputs are stable. imem_ack is ignored.
  - On next_pc=1: pc<=new PC, instr_valid<=0, → FETCH, imem_req<=1.
- New PC computation:
  - pc_src=0: pc+1.
  - pc_src=1 and opcode==4'b0111 (J): IR[PC_WIDTH-1:0], absolute.
  - pc_src=1 and any other opcode (BEQ/BNE): pc+1+sext(IR[5:0]).
  - All arithmetic is modulo 2^PC_WIDTH; wrap-around is silent.
- HALT: halted=1, instr_valid=1, imem_req=0. Ignores fetch_en, next_pc and ack. Exits only on reset.
- Decoded fields are combinational from IR. They are don't-care while instr_valid=0, but must not glitch in HOLD.
- imm = IR[5:0] sign-extended to DATA_WIDTH.

Test Plan:
- Reset, fetch_en=1, ack 2 cycles after req with rdata=16'hA2C8 → imem_addr=0x00; then instr_valid=1, opcode=4'hA, rd=1, rs1=3, rs2=1, imm=8'h08, imem_req=0.
- In HOLD at pc=0x05, next_pc=1, pc_src=0 → pc=0x06, imem_req=1, instr_valid=0 next cycle. Zero-wait ack → instr_valid 1 cycle later.
- pc=0x10, IR=16'h803E (BEQ, imm6=-2), next_pc=1, pc_src=1 → pc=0x0F. With IR imm6=+5 instead → pc=0x16.
- pc=0x20, IR=16'h703C (J), next_pc=1, pc_src=1 → pc=0x3C. Separately, pc=0xFF, pc_src=0 → pc=0x00 (wrap).
- Fetch of 16'hF000 → halted=1. Subsequent next_pc, fetch_en and ack pulses cause no change in pc or imem_req. Reset → halted=0, pc=0x00.
- Reset asserted while imem_req=1, with ack arriving in the same cycle → IR=0, instr_valid=0, imem_req=0, state IDLE.
